sysid_probe_master: RTL and testbench
=====================================

# sysid_probe_master

Avalon-MM read master that interrogates the system ID peripheral: reads the ID word (word offset 0) and the build timestamp word (word offset 1), compares both against expected values, and reports pass/fail. It sits on the HPS-to-FPGA-side fabric next to the system ID slave and gates bring-up logic: application blocks stay held off until `pass` asserts. Each read has a bounded timeout, so a missing or mis-mapped slave is reported as an error instead of hanging the system.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte address of the system ID slave; the ID is at BASE_ADDR and the timestamp at BASE_ADDR+4.
- `EXPECTED_ID`, 32'd0: value the ID word must equal.
- `EXPECTED_TS`, 32'd1617249225: value the timestamp word must equal.
- `TIMEOUT_CYCLES`, 255: cycles allowed per read, from read assertion to `readdatavalid`; legal range 1..65535.
- `AUTO_START`, 1: when 1, one probe starts automatically after reset release.
- `clock`  in  1  sole clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to run a probe; sampled only in IDLE.
- `avm_address`  out  32  byte address.
- `avm_read`  out  1  read request.
- `avm_waitrequest`  in  1  slave stall.
- `avm_readdata`  in  32  read data.
- `avm_readdatavalid`  in  1  read data qualifier (pipelined reads).
- `busy`  out  1  high from probe launch until DONE.
- `done`  out  1  one-cycle pulse when a probe completes.
- `pass`  out  1  last probe matched both words with no timeout; held.
- `timeout_err`  out  1  last probe timed out; held.
- `id_value`  out  32  last captured ID word; held.
- `ts_value`  out  32  last captured timestamp word; held.

## Operation
- States: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, DONE.
- IDLE -> RD_ID on `start`=1, or on the first cycle after reset when AUTO_START=1. Launching a probe clears `pass`, `timeout_err`, `id_value` and `ts_value` to 0.
- RD_ID: `avm_read`=1 and `avm_address`=BASE_ADDR. Both are held while `avm_waitrequest`=1. When `avm_waitrequest`=0, the read is accepted and the state moves to WT_ID with `avm_read`=0.
- WT_ID: on `avm_readdatavalid`=1, capture `avm_readdata` into `id_value` and go to RD_TS.
- RD_TS and WT_TS: same as RD_ID and WT_ID, with address BASE_ADDR+4 and capture into `ts_value`. After capture, go to DONE.
- DONE: for one cycle, `done`=1. `pass` = (`id_value`==EXPECTED_ID) && (`ts_value`==EXPECTED_TS) && !`timeout_err`. Next state is IDLE.
- Timeout:
  - A 16-bit counter clears on entry to RD_ID and on entry to RD_TS, and increments in RD_x and WT_x.
  - When the counter reaches TIMEOUT_CYCLES, the FSM deasserts `avm_read`, sets `timeout_err`=1 and goes to DONE; `pass`=0.
  - This is a deliberate abandon: `avm_read` is dropped even while `avm_waitrequest`=1.
- `avm_readdatavalid` is ignored in IDLE, RD_x and DONE. Stray or late responses are discarded.
- `start` is ignored while `busy`=1 and in DONE. Pulses there are not queued.
- Reset values: state IDLE; `avm_read`=0, `avm_address`=0, `busy`=0, `done`=0, `pass`=0, `timeout_err`=0, `id_value`=0, `ts_value`=0. The timeout counter resets to 0.
- Asserting reset mid-probe aborts immediately: `avm_read` drops asynchronously. After release, AUTO_START launches a fresh probe.

## Timing
- `start` sampled at edge N -> `avm_read`=1 from edge N+1.
- Read accepted at edge M (`waitrequest`=0) -> `avm_read` is low from M+1.
- Data capture happens on the edge where `readdatavalid`=1. The next read is issued on the following cycle.
- Minimum probe with zero waitstates and 1-cycle read latency: `start` -> `done` pulse in 6 cycles. `busy` is high for 5 cycles, then `done` for 1.
- `pass`, `timeout_err`, `id_value` and `ts_value` are valid from the `done` cycle. They hold until the next launch.
- Exactly one outstanding read at any time.

## Test plan
- Slave with 0 waitstates and 1-cycle latency returning 0 then 1617249225; `start` pulse:
  - addresses BASE and BASE+4 are issued in order;
  - `done` pulses 6 cycles after `start`;
  - `pass`=1, `id_value`=0, `ts_value`=1617249225.
- Same slave, but the timestamp word returns 1617249224 -> `pass`=0, `timeout_err`=0, `ts_value`=1617249224.
- `waitrequest` held for 3 cycles on each read:
  - address and `avm_read` are stable throughout the stall;
  - `pass`=1, with `done` arriving 6 cycles later than the zero-waitstate case.
- TIMEOUT_CYCLES=10 and `readdatavalid` never asserted:
  - `avm_read` drops and `done` pulses within 11 cycles of the first read;
  - `timeout_err`=1, `pass`=0.
  - A late `readdatavalid` injected afterwards changes no output.
- AUTO_START=1 -> a probe runs without `start`. Then:
  - a second `start` during `busy` is ignored;
  - asserting `reset_n`=0 mid-WT_TS clears all outputs at once;
  - after release, a new probe completes with `pass`=1.

Source files
------------

// File: rtl/sysid_probe_master.sv
// sysid_probe_master: Avalon-MM read master that fetches the system ID and
// build timestamp words, checks them against expected values and reports a
// held pass/timeout result. Every read is bounded, so a missing slave shows up
// as timeout_err instead of a hung bus.
module sysid_probe_master #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1617249225,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {IDLE, RD_ID, WT_ID, RD_TS, WT_TS, DONE} state_t;

  // Last counter value still inside the allowed window for one read.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic        launch;     // probe accepted, RD_ID follows next cycle
  logic        auto_pend;  // implicit start request right after reset release
  logic        go;
  logic [15:0] cnt;
  logic        tmo_hit;
  logic        tmo_exit;

  // A launch is taken only from an idle master with no launch in flight.
  assign go      = (state == IDLE) && !launch && (start || auto_pend);
  assign tmo_hit = (cnt >= TMO_LAST);
  // Leaving for DONE without the timestamp capture means the read was abandoned.
  assign tmo_exit = (state_nxt == DONE) && !(state == WT_TS && avm_readdatavalid);

  // State register; reset drops the bus request asynchronously via the decode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: handshake/data take priority, otherwise the timeout abandons.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (launch) state_nxt = RD_ID;
      RD_ID: if (!avm_waitrequest)       state_nxt = WT_ID;
             else if (tmo_hit)           state_nxt = DONE;
      WT_ID: if (avm_readdatavalid)      state_nxt = RD_TS;
             else if (tmo_hit)           state_nxt = DONE;
      RD_TS: if (!avm_waitrequest)       state_nxt = WT_TS;
             else if (tmo_hit)           state_nxt = DONE;
      WT_TS: if (avm_readdatavalid || tmo_hit) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: bus request, status strobes.
  always_comb begin
    avm_read    = 1'b0;
    avm_address = 32'd0;
    done        = 1'b0;
    busy        = launch;
    unique case (state)
      RD_ID: begin avm_read = 1'b1; avm_address = BASE_ADDR;         busy = 1'b1; end
      WT_ID: busy = 1'b1;
      RD_TS: begin avm_read = 1'b1; avm_address = BASE_ADDR + 32'd4; busy = 1'b1; end
      WT_TS: busy = 1'b1;
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Launch pipeline stage and the one-shot auto start after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      launch    <= 1'b0;
      auto_pend <= AUTO_START;
    end else begin
      launch    <= go;
      auto_pend <= 1'b0;
    end
  end

  // Per-read timeout counter: restarts when a new read phase is entered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      cnt <= 16'd0;
    else if (state_nxt != state && (state_nxt == RD_ID || state_nxt == RD_TS))
      cnt <= 16'd0;
    else if (state == RD_ID || state == WT_ID || state == RD_TS || state == WT_TS)
      cnt <= cnt + 16'd1;
  end

  // Captured words and verdict; cleared at launch, held until the next one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pass        <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= 32'd0;
      ts_value    <= 32'd0;
    end else if (go) begin
      pass        <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= 32'd0;
      ts_value    <= 32'd0;
    end else begin
      if (state == WT_ID && avm_readdatavalid)
        id_value <= avm_readdata;
      if (state == WT_TS && avm_readdatavalid) begin
        ts_value <= avm_readdata;
        pass     <= (id_value == EXPECTED_ID) && (avm_readdata == EXPECTED_TS) && !timeout_err;
      end
      if (tmo_exit) begin
        timeout_err <= 1'b1;
        pass        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sysid_probe_master.sv
// tb_sysid_probe_master: directed probes against a configurable Avalon slave
// model; expected addresses and verdicts are queued when a probe is launched
// and checked when the master issues reads and pulses done.
module tb_sysid_probe_master;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] EID  = 32'hC0DE_0001;
  localparam logic [31:0] ETS  = 32'd1617249225;
  localparam int          TMO  = 10;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_readdatavalid = 1'b0;
  logic        busy, done, pass, timeout_err;
  logic [31:0] id_value, ts_value;

  sysid_probe_master #(
    .BASE_ADDR(BASE), .EXPECTED_ID(EID), .EXPECTED_TS(ETS),
    .TIMEOUT_CYCLES(TMO), .AUTO_START(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .pass(pass), .timeout_err(timeout_err),
    .id_value(id_value), .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        pass;
    logic        tmo;
    logic [31:0] id;
    logic [31:0] ts;
  } res_t;

  res_t        res_q[$];
  logic [31:0] addr_q[$];
  int nassert = 0;
  int nfail   = 0;
  int cyc     = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nassert++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Slave configuration, written only by the stimulus block.
  int          ws = 0;
  bit          respond = 1'b1;
  logic [31:0] id_word = EID;
  logic [31:0] ts_word = ETS;
  bit          inj = 1'b0;
  logic [31:0] inj_data = 32'd0;
  bit          stall_chk = 1'b0;

  // Slave model: ws waitstates per read, then data on the following cycle.
  int          wcnt = 0;
  bit          resp_pend = 1'b0;
  logic [31:0] resp_data = 32'd0;
  initial begin
    forever begin
      @(negedge clock);
      avm_readdatavalid = 1'b0;
      if (resp_pend) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = resp_data;
        resp_pend         = 1'b0;
      end else if (inj) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = inj_data;
      end
      if (!reset_n) begin
        avm_waitrequest = 1'b0;
        wcnt            = 0;
        resp_pend       = 1'b0;
      end else if (avm_read) begin
        if (wcnt < ws) begin
          avm_waitrequest = 1'b1;
          wcnt++;
        end else begin
          avm_waitrequest = 1'b0;
          wcnt            = 0;
          if (respond) begin
            resp_pend = 1'b1;
            resp_data = (avm_address == BASE) ? id_word : ts_word;
          end
        end
      end else begin
        avm_waitrequest = 1'b0;
        wcnt            = 0;
      end
    end
  end

  // Monitor: sampled mid-cycle, after the slave has settled its inputs.
  int          done_cnt = 0, done_cyc = 0, rd_rise_cyc = 0;
  int          busy_run = 0, busy_len = 0, ts_acc_cnt = 0;
  logic        prev_read = 1'b0, prev_wait = 1'b0, prev_busy = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (!reset_n) begin
        prev_read = 1'b0; prev_wait = 1'b0; prev_busy = 1'b0; busy_run = 0;
      end else begin
        if (stall_chk && prev_read && prev_wait) begin
          check("stall_read", {31'd0, avm_read}, 32'd1);
          check("stall_addr", avm_address, prev_addr);
        end
        if (avm_read && !prev_read) rd_rise_cyc = cyc;
        if (avm_read && !avm_waitrequest) begin
          if (addr_q.size() == 0) check("unexpected_read", avm_address, 32'hFFFF_FFFF);
          else check("read_addr", avm_address, addr_q.pop_front());
          if (avm_address == BASE + 32'd4) ts_acc_cnt++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          if (res_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
          else begin
            res_t r;
            r = res_q.pop_front();
            check("pass", {31'd0, pass}, {31'd0, r.pass});
            check("timeout_err", {31'd0, timeout_err}, {31'd0, r.tmo});
            check("id_value", id_value, r.id);
            check("ts_value", ts_value, r.ts);
          end
        end
        if (busy) busy_run++;
        else if (prev_busy) begin busy_len = busy_run; busy_run = 0; end
        prev_read = avm_read; prev_wait = avm_waitrequest;
        prev_addr = avm_address; prev_busy = busy;
      end
    end
  end

  task automatic expect_probe(input logic p, input logic t, input logic [31:0] id,
                              input logic [31:0] ts, input int naddr);
    res_t r;
    r.pass = p; r.tmo = t; r.id = id; r.ts = ts;
    res_q.push_back(r);
    if (naddr > 0) addr_q.push_back(BASE);
    if (naddr > 1) addr_q.push_back(BASE + 32'd4);
  endtask

  task automatic pulse_start(output int t0);
    @(negedge clock);
    start = 1'b1;
    t0 = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      #2;
      if (done_cnt != n0) return;
    end
    check("done_wait_expired", 32'd0, 32'd1);
  endtask

  int t0, rel, n0, a0;

  initial begin
    // Reset state.
    repeat (3) @(negedge clock);
    #1;
    check("rst_read", {31'd0, avm_read}, 32'd0);
    check("rst_addr", avm_address, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_tmo", {31'd0, timeout_err}, 32'd0);
    check("rst_id", id_value, 32'd0);
    check("rst_ts", ts_value, 32'd0);

    // Auto start after release; a start during busy is ignored.
    expect_probe(1'b1, 1'b0, EID, ETS, 2);
    n0 = done_cnt;
    @(negedge clock);
    reset_n = 1'b1;
    rel = cyc;
    @(negedge clock);
    #2;
    check("auto_busy", {31'd0, busy}, 32'd1);
    pulse_start(t0);
    wait_done(n0);
    check("auto_latency", done_cyc - rel, 32'd6);
    n0 = done_cnt;
    repeat (15) @(negedge clock);
    check("no_queued_start", done_cnt, n0);

    // Zero waitstates, good words: 6-cycle start to done, busy for 5.
    expect_probe(1'b1, 1'b0, EID, ETS, 2);
    n0 = done_cnt;
    pulse_start(t0);
    wait_done(n0);
    check("min_latency", done_cyc - t0, 32'd6);
    check("busy_len", busy_len, 32'd5);

    // Timestamp off by one.
    ts_word = ETS - 32'd1;
    expect_probe(1'b0, 1'b0, EID, ETS - 32'd1, 2);
    n0 = done_cnt;
    pulse_start(t0);
    wait_done(n0);

    // Wrong ID word.
    ts_word = ETS;
    id_word = 32'h0000_0005;
    expect_probe(1'b0, 1'b0, 32'h0000_0005, ETS, 2);
    n0 = done_cnt;
    pulse_start(t0);
    wait_done(n0);
    id_word = EID;

    // Three waitstates on each read: bus held stable, 6 cycles later.
    ws = 3;
    stall_chk = 1'b1;
    expect_probe(1'b1, 1'b0, EID, ETS, 2);
    n0 = done_cnt;
    pulse_start(t0);
    wait_done(n0);
    check("ws_latency", done_cyc - t0, 32'd12);
    stall_chk = 1'b0;
    ws = 0;

    // No read data ever: timeout, then a late response is ignored.
    respond = 1'b0;
    expect_probe(1'b0, 1'b1, 32'd0, 32'd0, 1);
    n0 = done_cnt;
    pulse_start(t0);
    wait_done(n0);
    check("tmo_window", {31'd0, (done_cyc - rd_rise_cyc >= TMO) && (done_cyc - rd_rise_cyc <= TMO + 1)}, 32'd1);
    check("tmo_read_low", {31'd0, avm_read}, 32'd0);
    repeat (2) @(negedge clock);
    @(posedge clock);
    inj_data = EID;
    inj = 1'b1;
    @(posedge clock);
    inj = 1'b0;
    repeat (2) @(negedge clock);
    #2;
    check("late_tmo", {31'd0, timeout_err}, 32'd1);
    check("late_pass", {31'd0, pass}, 32'd0);
    check("late_id", id_value, 32'd0);
    check("late_busy", {31'd0, busy}, 32'd0);
    respond = 1'b1;

    // Slave stalls forever: read is abandoned while waitrequest is high.
    ws = 1000;
    expect_probe(1'b0, 1'b1, 32'd0, 32'd0, 0);
    n0 = done_cnt;
    pulse_start(t0);
    wait_done(n0);
    check("stall_tmo_window", {31'd0, (done_cyc - rd_rise_cyc >= TMO) && (done_cyc - rd_rise_cyc <= TMO + 1)}, 32'd1);
    check("stall_tmo_read_low", {31'd0, avm_read}, 32'd0);
    ws = 0;
    repeat (2) @(negedge clock);

    // Reset during WT_TS clears everything at once; auto start reruns.
    expect_probe(1'b1, 1'b0, EID, ETS, 2);
    a0 = ts_acc_cnt;
    pulse_start(t0);
    for (int i = 0; i < 50 && ts_acc_cnt == a0; i++) begin
      @(negedge clock);
      #2;
    end
    check("ts_read_seen", {31'd0, ts_acc_cnt != a0}, 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort_read", {31'd0, avm_read}, 32'd0);
    check("abort_addr", avm_address, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_id", id_value, 32'd0);
    check("abort_ts", ts_value, 32'd0);
    check("abort_addr_q", addr_q.size(), 32'd0);
    res_q.delete();
    addr_q.delete();
    expect_probe(1'b1, 1'b0, EID, ETS, 2);
    n0 = done_cnt;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    rel = cyc;
    wait_done(n0);
    check("rerun_latency", done_cyc - rel, 32'd6);

    repeat (3) @(negedge clock);
    check("res_q_drained", res_q.size(), 32'd0);
    check("addr_q_drained", addr_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
